pause_dim_ctrl: RTL

// User-pause controller and video dimmer between the arcade core video output and arcade_video.

---
 rtl/pause_dim_ctrl_if.sv | 68 ++++++
 rtl/pause_dim_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pause_dim_ctrl_if.sv
// Signal bundle between the arcade core video/pause side and the pause/dim
// controller. The controller takes the slave view; whoever drives the core
// side (core wrapper or bench) takes the master view.
interface pause_dim_ctrl_if;

  // Control inputs to the controller
  logic        pause_btn;
  logic        hs_access;
  logic        ce_pix;

  // Core video into the controller
  logic [23:0] rgb_in;
  logic        hblank_in;
  logic        vblank_in;
  logic        hs_in;
  logic        vs_in;

  // Pause status back to the core / OSD
  logic        pause;
  logic        user_paused;
  logic        dim_active;

  // Re-registered video toward arcade_video
  logic [23:0] rgb_out;
  logic        hblank_out;
  logic        vblank_out;
  logic        hs_out;
  logic        vs_out;

  modport master (
    output pause_btn,
    output hs_access,
    output ce_pix,
    output rgb_in,
    output hblank_in,
    output vblank_in,
    output hs_in,
    output vs_in,
    input  pause,
    input  user_paused,
    input  dim_active,
    input  rgb_out,
    input  hblank_out,
    input  vblank_out,
    input  hs_out,
    input  vs_out
  );

  modport slave (
    input  pause_btn,
    input  hs_access,
    input  ce_pix,
    input  rgb_in,
    input  hblank_in,
    input  vblank_in,
    input  hs_in,
    input  vs_in,
    output pause,
    output user_paused,
    output dim_active,
    output rgb_out,
    output hblank_out,
    output vblank_out,
    output hs_out,
    output vs_out
  );

endinterface

// File: rtl/pause_dim_ctrl.sv
// User-pause controller and video dimmer sitting between the arcade core
// video output and arcade_video. A pause-button press toggles user pause;
// the hiscore RAM-access request is OR-ed into the core pause. After
// DIM_TIMEOUT clk cycles of user pause the picture is dimmed, but the dim
// only engages or releases at a frame boundary (vertical-blank rising edge)
// so a frame is never half dimmed. Video timing and RGB are re-registered
// together on ce_pix so sync/blank stay aligned with the pixel data.
module pause_dim_ctrl #(
  parameter logic [31:0] DIM_TIMEOUT = 32'h0727_0E00,
  parameter int unsigned DIM_SHIFT   = 1
) (
  input  logic             clk,
  input  logic             reset,
  pause_dim_ctrl_if.slave  bus
);

  // A zero timeout would never be reached by a counter starting at zero,
  // so it behaves as the shortest possible timeout instead.
  localparam logic [31:0] TIMEOUT_EFF = (DIM_TIMEOUT == 32'd0) ? 32'd1 : DIM_TIMEOUT;
  localparam logic [31:0] TIMER_LAST  = TIMEOUT_EFF - 32'd1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_DIMMED = 2'd2
  } state_e;

  state_e      state_q;
  state_e      state_d;
  logic [31:0] timer_q;
  logic [31:0] timer_d;
  logic        btn_q;
  logic        btn_d;
  logic        press;

  logic        vbl_q;
  logic        vbl_d;
  logic        dim_active_q;
  logic        dim_active_d;
  logic [23:0] rgb_out_q;
  logic [23:0] rgb_out_d;
  logic        hblank_out_q;
  logic        hblank_out_d;
  logic        vblank_out_q;
  logic        vblank_out_d;
  logic        hs_out_q;
  logic        hs_out_d;
  logic        vs_out_q;
  logic        vs_out_d;

  logic [23:0] rgb_dimmed;
  logic        vbl_rise;

  // A held button must toggle pause only once, so only the rising edge counts.
  assign btn_d = bus.pause_btn;
  assign press = bus.pause_btn & ~btn_q;

  // Each channel is shifted on its own so no bit leaks into the next colour.
  assign rgb_dimmed = {bus.rgb_in[23:16] >> DIM_SHIFT,
                       bus.rgb_in[15:8]  >> DIM_SHIFT,
                       bus.rgb_in[7:0]   >> DIM_SHIFT};

  // Frame boundary: vertical blank going high, seen on a pixel enable.
  assign vbl_rise = bus.vblank_in & ~vbl_q;

  // Pause toggle state machine with the idle timer that leads to dimming.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      ST_RUN: begin
        if (press) begin
          state_d = ST_PAUSED;
          timer_d = '0;
        end
      end
      ST_PAUSED: begin
        if (press) begin
          state_d = ST_RUN;
          timer_d = '0;
        end else begin
          if (timer_q != '1) begin
            timer_d = timer_q + 32'd1;
          end
          if (timer_q >= TIMER_LAST) begin
            state_d = ST_DIMMED;
          end
        end
      end
      ST_DIMMED: begin
        if (press) begin
          state_d = ST_RUN;
          timer_d = '0;
        end
      end
      default: begin
        state_d = ST_RUN;
        timer_d = '0;
      end
    endcase
  end

  // Control registers: FSM state, idle timer and button edge history.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      timer_q <= '0;
      btn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      btn_q   <= btn_d;
    end
  end

  // Pixel-rate pipeline: latch dim at frame start (from the pre-update state)
  // and re-register video, blanking RGB and dimming it when active.
  always_comb begin
    vbl_d        = vbl_q;
    dim_active_d = dim_active_q;
    rgb_out_d    = rgb_out_q;
    hblank_out_d = hblank_out_q;
    vblank_out_d = vblank_out_q;
    hs_out_d     = hs_out_q;
    vs_out_d     = vs_out_q;
    if (bus.ce_pix) begin
      vbl_d        = bus.vblank_in;
      hblank_out_d = bus.hblank_in;
      vblank_out_d = bus.vblank_in;
      hs_out_d     = bus.hs_in;
      vs_out_d     = bus.vs_in;
      if (vbl_rise) begin
        dim_active_d = (state_q == ST_DIMMED);
      end
      if (bus.hblank_in || bus.vblank_in) begin
        rgb_out_d = '0;
      end else if (dim_active_q) begin
        rgb_out_d = rgb_dimmed;
      end else begin
        rgb_out_d = bus.rgb_in;
      end
    end
  end

  // Video and dim-latch registers, cleared so nothing stale reaches the scaler.
  always_ff @(posedge clk) begin
    if (reset) begin
      vbl_q        <= 1'b0;
      dim_active_q <= 1'b0;
      rgb_out_q    <= '0;
      hblank_out_q <= 1'b0;
      vblank_out_q <= 1'b0;
      hs_out_q     <= 1'b0;
      vs_out_q     <= 1'b0;
    end else begin
      vbl_q        <= vbl_d;
      dim_active_q <= dim_active_d;
      rgb_out_q    <= rgb_out_d;
      hblank_out_q <= hblank_out_d;
      vblank_out_q <= vblank_out_d;
      hs_out_q     <= hs_out_d;
      vs_out_q     <= vs_out_d;
    end
  end

  // The hiscore request pauses the core directly, without touching the FSM.
  assign bus.user_paused = (state_q != ST_RUN);
  assign bus.pause       = (state_q != ST_RUN) | bus.hs_access;
  assign bus.dim_active  = dim_active_q;
  assign bus.rgb_out     = rgb_out_q;
  assign bus.hblank_out  = hblank_out_q;
  assign bus.vblank_out  = vblank_out_q;
  assign bus.hs_out      = hs_out_q;
  assign bus.vs_out      = vs_out_q;

endmodule
